rk2_link_sched: RTL

- Schedules a shared 4-bit serial pattern link between N local requesters, using round-robin arbitration.
- Drives the link's active-low select (cs) and serial data (d) toward the rk2 pattern receiver.
- Captures the receiver's active-low ack/err response and returns a per-requester completion with pass/fail/timeout status.
- Sits between requesting control logic and the single receiver instance.

---
 rtl/rk2_pkg.sv | 15 +
 rtl/rk2_link_sched_if.sv | 36 +++
 rtl/rk2_rr_arb.sv | 28 ++
 rtl/rk2_link_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rk2_pkg.sv
// Shared types and constants for the rk2 serial pattern link scheduler.
package rk2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } rk2_state_e;

  localparam int         RK2_W         = 4;
  localparam logic [3:0] RK2_PATTERN   = 4'b0101;
  localparam int         RK2_MAX_RETRY = 2;

endpackage

// File: rtl/rk2_link_sched_if.sv
// Requester-side and link-side signals of the rk2 link scheduler, bundled with master/slave views.
interface rk2_link_sched_if
  import rk2_pkg::*;
#(
  parameter int N = 4,
  parameter int W = RK2_W
);
  localparam int IW = $clog2(N);

  // Handshake: a requester raises req[i] with a stable data word and keeps both until it
  // sees its one-cycle done[i]; pass/timeout are valid with done and hold until the next one.
  // On the link, cs/d are driven by the scheduler and ack/err (active-low) come back from the receiver.
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic           busy;
  logic [IW-1:0]  gnt_id;
  logic [N-1:0]   done;
  logic           pass;
  logic           timeout;
  logic           cs;
  logic           d;
  logic           ack;
  logic           err;
  rk2_state_e     state_dbg;

  modport master (
    input  req, data, ack, err,
    output busy, gnt_id, done, pass, timeout, cs, d, state_dbg
  );

  modport slave (
    output req, data, ack, err,
    input  busy, gnt_id, done, pass, timeout, cs, d, state_dbg
  );

endinterface

// File: rtl/rk2_rr_arb.sv
// Combinational round-robin search: first set req strictly after ptr, wrapping around.
module rk2_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] win,
  output logic          valid
);

  logic [IW-1:0] idx;

  // Walk the candidates from farthest to nearest so the nearest set request is written last.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        win   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rk2_link_sched.sv
// Round-robin scheduler for the shared rk2 serial pattern link with per-requester completion status.
// Build macro RK2_LINK_RETRY_EN: an err response triggers up to two automatic resends of the word.
module rk2_link_sched
  import rk2_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = RK2_W,
  parameter int TMO = 8
) (
  input logic              clk,
  input logic              rst,
  rk2_link_sched_if.master lnk
);

  localparam int           IW       = $clog2(N);
  localparam int           BW       = $clog2(W);
  localparam int           CW       = $clog2(TMO);
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  rk2_state_e    state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] gnt_id, gnt_nxt;
  logic [W-1:0]  word, word_nxt, word_sel;
  logic [BW-1:0] bit_cnt, bit_nxt, bit_inc;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic          busy, busy_nxt;
  logic          pass, pass_nxt;
  logic          timeout, tmo_nxt;
  logic          cs, cs_nxt;
  logic          d, d_nxt;
  logic [N-1:0]  done, done_nxt;
  logic          arb_valid;
  logic [IW-1:0] arb_win;

`ifdef RK2_LINK_RETRY_EN
  logic [1:0] retry_cnt, retry_nxt;
  logic       resend, resend_nxt;
`endif

  rk2_rr_arb #(.N(N)) u_arb (
    .req   (lnk.req),
    .ptr   (ptr),
    .win   (arb_win),
    .valid (arb_valid)
  );

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_win == IW'(i)) word_sel = lnk.data[i*W +: W];
    end
  end

  assign bit_inc = bit_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt_id;
    word_nxt  = word;
    bit_nxt   = bit_cnt;
    wait_nxt  = wait_cnt;
    busy_nxt  = busy;
    pass_nxt  = pass;
    tmo_nxt   = timeout;
    cs_nxt    = cs;
    d_nxt     = d;
    done_nxt  = '0;
`ifdef RK2_LINK_RETRY_EN
    retry_nxt  = retry_cnt;
    resend_nxt = resend;
`endif
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          word_nxt  = word_sel;
          gnt_nxt   = arb_win;
          ptr_nxt   = arb_win;
          busy_nxt  = 1'b1;
          cs_nxt    = 1'b0;
          d_nxt     = word_sel[0];
          bit_nxt   = '0;
          state_nxt = SEND;
`ifdef RK2_LINK_RETRY_EN
          retry_nxt  = '0;
          resend_nxt = 1'b0;
`endif
        end
      end
      SEND: begin
        if (bit_cnt == BW'(W - 1)) begin
          cs_nxt    = 1'b1;
          d_nxt     = 1'b0;
          wait_nxt  = '0;
          state_nxt = RESP;
        end else begin
          bit_nxt = bit_inc;
          d_nxt   = word[bit_inc];
        end
      end
      RESP: begin
        // err has priority over ack when both are low in the same cycle.
        if (!lnk.err) begin
`ifdef RK2_LINK_RETRY_EN
          if (retry_cnt != 2'(RK2_MAX_RETRY)) begin
            retry_nxt  = retry_cnt + 1'b1;
            resend_nxt = 1'b1;
          end else begin
            done_nxt = ONE_HOT0 << gnt_id;
            pass_nxt = 1'b0;
            tmo_nxt  = 1'b0;
          end
`else
          done_nxt = ONE_HOT0 << gnt_id;
          pass_nxt = 1'b0;
          tmo_nxt  = 1'b0;
`endif
          state_nxt = GAP;
        end else if (!lnk.ack) begin
          done_nxt  = ONE_HOT0 << gnt_id;
          pass_nxt  = 1'b1;
          tmo_nxt   = 1'b0;
          state_nxt = GAP;
        end else if (wait_cnt == CW'(TMO - 1)) begin
          // A silent receiver never pulled its lines low, so no settle gap is needed.
          done_nxt  = ONE_HOT0 << gnt_id;
          pass_nxt  = 1'b0;
          tmo_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      GAP: begin
        if (lnk.ack && lnk.err) begin
`ifdef RK2_LINK_RETRY_EN
          if (resend) begin
            resend_nxt = 1'b0;
            bit_nxt    = '0;
            cs_nxt     = 1'b0;
            d_nxt      = word[0];
            state_nxt  = SEND;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
`else
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= IW'(N - 1);
      gnt_id   <= '0;
      word     <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      cs       <= 1'b1;
      d        <= 1'b0;
      done     <= '0;
`ifdef RK2_LINK_RETRY_EN
      retry_cnt <= '0;
      resend    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_id   <= gnt_nxt;
      word     <= word_nxt;
      bit_cnt  <= bit_nxt;
      wait_cnt <= wait_nxt;
      busy     <= busy_nxt;
      pass     <= pass_nxt;
      timeout  <= tmo_nxt;
      cs       <= cs_nxt;
      d        <= d_nxt;
      done     <= done_nxt;
`ifdef RK2_LINK_RETRY_EN
      retry_cnt <= retry_nxt;
      resend    <= resend_nxt;
`endif
    end
  end

  assign lnk.busy      = busy;
  assign lnk.gnt_id    = gnt_id;
  assign lnk.done      = done;
  assign lnk.pass      = pass;
  assign lnk.timeout   = timeout;
  assign lnk.cs        = cs;
  assign lnk.d         = d;
  assign lnk.state_dbg = state;

endmodule
